logic_accum: RTL and testbench

//  Streaming bitwise accumulator, parametrised successor to the 2-input OR gate.

---
 rtl/logic_accum_pkg.sv | 17 +
 rtl/logic_op_unit.sv | 25 ++
 rtl/logic_accum.sv | 123 ++++++++++++
 tb/tb_logic_accum.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_accum_pkg.sv
// Shared op codes and FSM state encodings for the streaming bitwise accumulator.
package logic_accum_pkg;

   typedef enum logic [1:0] {
      OP_OR  = 2'b00,
      OP_AND = 2'b01,
      OP_XOR = 2'b10,
      OP_NOR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ACC  = 2'b01,
      S_HOLD = 2'b10
   } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational fold step: combines the running accumulator with one input word.
module logic_op_unit
   import logic_accum_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_e              op,
   output logic [WIDTH-1:0] y
);

   // NOR folds as OR; the final inversion is applied once when the frame closes.
   always_comb begin
      y = '0;
      unique case (op)
         OP_OR,
         OP_NOR: y = a | b;
         OP_AND: y = a & b;
         OP_XOR: y = a ^ b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_accum.sv
// Folds a valid/ready frame of words into one result word and holds it until the
// consumer accepts it.
module logic_accum
   import logic_accum_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MAX_LEN = 16,
   localparam int unsigned CW     = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    out_count,
   output logic             out_ovf
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   op_e              op_q, op_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [CW-1:0]    out_count_q, out_count_d;
   logic             out_ovf_q, out_ovf_d;

   logic [WIDTH-1:0] fold;
   logic             beat;
   logic             close;

   logic_op_unit #(
      .WIDTH (WIDTH)
   ) u_op (
      .a  (acc_q),
      .b  (in_data),
      .op (op_q),
      .y  (fold)
   );

   assign in_ready = (state_q != S_HOLD);
   assign beat     = in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;
      close       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (beat) begin
               acc_d   = in_data;
               op_d    = op_e'(op);
               cnt_d   = CW'(1);
               close   = in_last || (MAX_LEN == 1);
               state_d = close ? S_HOLD : S_ACC;
            end
         end
         S_ACC: begin
            if (beat) begin
               acc_d   = fold;
               cnt_d   = cnt_q + CW'(1);
               close   = in_last || (cnt_d == CW'(MAX_LEN));
               state_d = close ? S_HOLD : S_ACC;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Result registers load on the same edge that closes the frame.
      if (close) begin
         out_data_d  = (op_d == OP_NOR) ? ~acc_d : acc_d;
         out_count_d = cnt_d;
         out_ovf_d   = !in_last;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         op_q        <= OP_OR;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_logic_accum.sv
// Scoreboard bench for logic_accum with WIDTH=8, MAX_LEN=4 and directed frames.
module tb_logic_accum;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned MAX_LEN = 4;
   localparam int unsigned CW      = $clog2(MAX_LEN + 1);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [CW-1:0]    count;
      logic             ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       op;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    out_count;
   logic             out_ovf;

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   logic_accum #(
      .WIDTH   (WIDTH),
      .MAX_LEN (MAX_LEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .op        (op),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic [CW-1:0] c, input logic v);
      exp_t e;
      e.data  = d;
      e.count = c;
      e.ovf   = v;
      sb_q.push_back(e);
   endtask

   // Presents one word and returns just after the edge on which it was accepted.
   task automatic beat(input logic [7:0] d, input logic l, input logic [1:0] o);
      int n;
      in_data  = d;
      in_last  = l;
      op       = o;
      in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready stuck at 0 for data %0h", d);
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Monitor: compares every accepted result against the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got data %0h count %0d with empty scoreboard",
                     out_data, out_count);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_count", 32'(out_count), 32'(e.count));
            chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
         end
      end
   end

   initial begin
      rst       = 1'b1;
      op        = 2'b00;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_data", 32'(out_data), 32'd0);
      chk("reset_out_count", 32'(out_count), 32'd0);
      chk("reset_out_ovf", 32'(out_ovf), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;

      // OR frame and output latency
      push(8'h83, 3'd3, 1'b0);
      beat(8'h01, 1'b0, 2'b00);
      beat(8'h02, 1'b0, 2'b00);
      chk("or_valid_before_close", 32'(out_valid), 32'd0);
      beat(8'h80, 1'b1, 2'b00);
      chk("or_valid_after_close", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;

      // AND single beat, held without consumer
      out_ready = 1'b0;
      push(8'hF0, 3'd1, 1'b0);
      beat(8'hF0, 1'b1, 2'b01);
      repeat (2) begin
         @(negedge clk);
         chk("and_in_ready_hold", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // XOR with op changed mid-frame
      push(8'hF0, 3'd2, 1'b0);
      beat(8'hFF, 1'b0, 2'b10);
      beat(8'h0F, 1'b1, 2'b00);

      // NOR and single-beat OR of zero
      push(8'hFF, 3'd2, 1'b0);
      beat(8'h00, 1'b0, 2'b11);
      beat(8'h00, 1'b1, 2'b11);
      push(8'h00, 3'd1, 1'b0);
      beat(8'h00, 1'b1, 2'b00);

      // Overflow at MAX_LEN, then a fresh frame
      push(8'h01, 3'd4, 1'b1);
      repeat (4) beat(8'h01, 1'b0, 2'b00);
      push(8'h01, 3'd1, 1'b0);
      beat(8'h01, 1'b1, 2'b00);
      @(posedge clk);
      #1;

      // Backpressure: result stable and input blocked
      out_ready = 1'b0;
      push(8'hFF, 3'd2, 1'b0);
      beat(8'h3C, 1'b0, 2'b10);
      beat(8'hC3, 1'b1, 2'b10);
      repeat (5) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_data", 32'(out_data), 32'hFF);
         chk("bp_out_count", 32'(out_count), 32'd2);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset mid-frame discards the partial frame
      beat(8'h11, 1'b0, 2'b00);
      beat(8'h22, 1'b0, 2'b00);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      chk("midrst_out_count", 32'(out_count), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      push(8'hAA, 3'd1, 1'b0);
      beat(8'hAA, 1'b1, 2'b00);

      begin
         int n;
         n = 0;
         while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
         end
      end
      #1;
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
